// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states and port ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t CPU_ID    = 1'b0;
    localparam port_id_t LOADER_ID = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// port that did not own the previous access.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output port_id_t   winner
);

    always_comb begin
        winner = CPU_ID;
        if (req == 2'b11) begin
            winner = (last == CPU_ID) ? LOADER_ID : CPU_ID;
        end else if (req[LOADER_ID]) begin
            winner = LOADER_ID;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port (CPU / loader) arbiter in front of a single-port synchronous RAM.
// Each access takes IDLE -> ACC -> RESP; gnt marks ACC, ack marks RESP.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          c_gnt,
    output logic          l_gnt,
    output logic          c_ack,
    output logic          l_ack,
    output logic [DW-1:0] rdata,
    output logic          ram_rena,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_t        state, nstate;
    port_id_t      owner_q;
    port_id_t      winner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;

    rr_pick u_pick (
        .req    ({l_req, c_req}),
        .last   (owner_q),
        .winner (winner)
    );

    assign accept = (state == IDLE) && (c_req || l_req);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (c_req || l_req) nstate = ACC;
            ACC:     nstate = RESP;
            RESP:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // owner_q doubles as the round-robin history; reset to the loader so the
    // CPU wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q <= LOADER_ID;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            owner_q <= winner;
            if (winner == LOADER_ID) begin
                we_q    <= l_we;
                addr_q  <= l_addr;
                wdata_q <= l_wdata;
            end else begin
                we_q    <= c_we;
                addr_q  <= c_addr;
                wdata_q <= c_wdata;
            end
        end
    end

    always_comb begin
        c_gnt    = 1'b0;
        l_gnt    = 1'b0;
        c_ack    = 1'b0;
        l_ack    = 1'b0;
        rdata    = '0;
        ram_rena = 1'b0;
        ram_wena = 1'b0;
        ram_addr = addr_q;
        ram_din  = wdata_q;
        case (state)
            ACC: begin
                c_gnt    = (owner_q == CPU_ID);
                l_gnt    = (owner_q == LOADER_ID);
                ram_wena = we_q;
                ram_rena = !we_q;
            end
            RESP: begin
                c_ack = (owner_q == CPU_ID);
                l_ack = (owner_q == LOADER_ID);
                if (!we_q) rdata = ram_dout;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning the data width in bits.
REQ-003 SHALL have port clk  in  1  meaning the single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have ports c_req, c_we  in  1 each  meaning the CPU (port 0) access request and its write flag.
REQ-006 SHALL have ports c_addr  in  AW and c_wdata  in  DW  meaning the CPU access address and write data.
REQ-007 SHALL have ports l_req, l_we  in  1 each  meaning the loader/debug (port 1) access request and its write flag.
REQ-008 SHALL have ports l_addr  in  AW and l_wdata  in  DW  meaning the loader access address and write data.
REQ-009 SHALL have ports c_gnt, l_gnt  out  1 each  meaning a one-cycle pulse: request accepted, inputs latched.
REQ-010 SHALL have ports c_ack, l_ack  out  1 each  meaning a one-cycle pulse: access done, rdata valid on reads.
REQ-011 SHALL have port rdata  out  DW  meaning the shared read-data return bus.
REQ-012 SHALL have ports ram_rena, ram_wena  out  1 each  meaning the RAM read and write enables.
REQ-013 SHALL have ports ram_addr  out  AW and ram_din  out  DW  meaning the RAM address and write data.
REQ-014 SHALL have port ram_dout  in  DW  meaning the RAM read data, valid one cycle after ram_rena.

Function
REQ-015 SHALL implement FSM states IDLE, ACC and RESP.
REQ-016 IDLE: when c_req or l_req is high, SHALL pick the owner, latch its we/addr/wdata and owner id, and go to ACC; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: when both request, the port that was not the last owner wins; a single requester always wins.
REQ-018 The gnt of the owner SHALL be high for exactly the ACC cycle; the requester may drop req or change inputs afterwards.
REQ-019 ACC: SHALL drive ram_addr/ram_din from the latched values, with ram_wena=we and ram_rena=!we, then go to RESP.
REQ-020 Outside ACC, ram_rena and ram_wena SHALL be 0.
REQ-021 RESP: the owner's ack SHALL be high and rdata SHALL equal ram_dout for reads; the FSM then returns to IDLE.
REQ-022 A write SHALL also produce an ack in RESP; rdata is don't-care for writes.
REQ-023 Access latency from the accepting IDLE edge to ack SHALL be 2 cycles; peak throughput SHALL be one access per 3 cycles.
REQ-024 At most one gnt and one ack SHALL be high in any cycle, and never in the same state.
REQ-025 A req still high in the RESP cycle SHALL NOT be accepted until the next IDLE cycle; requests arriving during ACC or RESP wait without loss.

Reset
REQ-026 On rstn low, SHALL asynchronously force state=IDLE, all gnt/ack=0, ram_rena=ram_wena=0, latched addr/data=0, rdata=0, last owner=loader (CPU wins the first tie).
REQ-027 If reset is asserted mid-access, the in-flight access SHALL be dropped with no ack after rstn is released.

Structure
REQ-028 The state encodings and port-id constants (CPU=0, LOADER=1) SHALL live in a shared package used by the controller and its bench.
REQ-029 One sub-module SHALL be natural: rr_pick, a 2-way round-robin selector (inputs: req vector, last owner; output: winner id).

Verification
REQ-030 Scenario: after reset, a CPU read of 0x10 with RAM word 0x10 = 0xDEADBEEF -> c_gnt in cycle 1, ram_rena in cycle 1, c_ack with rdata=0xDEADBEEF in cycle 2.
REQ-031 Scenario: loader write of 0x55AA to 0x20, then CPU read of 0x20 -> l_ack, then c_ack with rdata=0x55AA.
REQ-032 Scenario: c_req and l_req held high together for 12 cycles -> grants alternate CPU, L, CPU, L with 4 accesses, each 3 cycles apart.
REQ-033 Scenario: l_req only, held high -> l_gnt every 3 cycles; c_gnt never high.
REQ-034 Scenario: rstn pulsed low during ACC of a read -> no ack, RAM enables 0 at once, next access starts cleanly from IDLE.
REQ-035 Scenario: c_req raised during RESP of a loader access -> c_gnt in the cycle after the next IDLE, with no lost request.
